// File: rtl/oet_sort_engine.sv
// Sequential odd-even transposition sorter: one compare/swap phase per clock,
// run-time order and compare mode, early exit once a full even+odd pass is clean.
module oet_sort_engine #(
  parameter int N      = 32,
  parameter int W      = 32,
  parameter int SIGNED = 0,
  parameter int PW     = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            descending,
  input  logic [N*W-1:0]  din,
  output logic            busy,
  output logic            done,
  output logic [N*W-1:0]  dout,
  output logic [PW-1:0]   phases
);

  typedef enum logic {IDLE, SORT} state_t;

  state_t              state, state_nx;
  logic [N-1:0][W-1:0] work, work_nx;
  logic                desc;
  logic                odd_phase;
  logic                swapped_prev;
  logic                swap_now;
  logic                finish;
  logic [PW-1:0]       count, count_nx;

  // Flipping the MSB maps two's complement order onto unsigned order.
  function automatic logic above(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] bias;
    bias = '0;
    if (SIGNED != 0) bias[W-1] = 1'b1;
    return (x ^ bias) > (y ^ bias);
  endfunction

  always_comb begin
    work_nx  = work;
    swap_now = 1'b0;
    for (int j = 0; j < N - 1; j++) begin
      if (((j % 2) == 1) == odd_phase) begin
        if (desc ? above(work[j+1], work[j]) : above(work[j], work[j+1])) begin
          work_nx[j]   = work[j+1];
          work_nx[j+1] = work[j];
          swap_now     = 1'b1;
        end
      end
    end
  end

  assign count_nx = count + PW'(1);
  assign finish   = (state == SORT) &&
                    ((odd_phase && !swap_now && !swapped_prev) || (count_nx == PW'(N)));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)  state_nx = SORT;
      SORT:    if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign busy = (state == SORT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work         <= '0;
      desc         <= 1'b0;
      count        <= '0;
      odd_phase    <= 1'b0;
      swapped_prev <= 1'b0;
      dout         <= '0;
      phases       <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          work         <= din;
          desc         <= descending;
          count        <= '0;
          odd_phase    <= 1'b0;
          swapped_prev <= 1'b0;
        end
      end else begin
        work         <= work_nx;
        count        <= count_nx;
        odd_phase    <= ~odd_phase;
        swapped_prev <= swap_now;
        if (finish) begin
          dout   <= work_nx;
          phases <= count_nx;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/oet_sort_engine.md
# oet_sort_engine

Parametrised, sequential odd-even transposition sorter that takes N words of W bits as one flattened vector and returns them sorted on the same flattened layout, word i at bits [(i+1)*W-1 : i*W]. It is the successor to the fixed 32×32 combinational sort network and sits beside the CPU as a memory-mapped accelerator. It adds run-time ascending/descending order, a signed/unsigned compare mode, a start/busy/done handshake, and early termination with a reported phase count.

## Interface
- N, default 32: number of elements; even, ≥ 2.
- W, default 32: element width in bits; ≥ 1.
- SIGNED, default 0: 1 compares as two's complement, 0 as unsigned.
- PW, default $clog2(N+1): width of the phase count.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to sort din; sampled only while busy=0.
- descending  in  1  order select, latched with start (0 ascending, 1 descending).
- din  in  N*W  unsorted input, flattened, word i at [(i+1)*W-1 : i*W].
- busy  out  1  sort in progress.
- done  out  1  one-cycle pulse when the result is valid.
- dout  out  N*W  last completed sorted result, same layout as din.
- phases  out  PW  number of phases executed for the last completed sort.

## Operation
- Internal state: work array a[0..N-1], latched order bit, phase counter, phase parity, and a swap flag for the previous phase.
- IDLE (busy=0): start=1 latches din into a[], latches descending, sets parity EVEN, sets count=0, goes to SORT.
- SORT: one phase per clock.
  - EVEN phase compares the pairs (0,1),(2,3),…,(N-2,N-1).
  - ODD phase compares the pairs (1,2),(3,4),…,(N-3,N-2).
- Compare/swap rule for a pair (j, j+1):
  - Ascending: swap iff a[j] > a[j+1].
  - Descending: swap iff a[j] < a[j+1].
  - Equal elements are never swapped, so the sort is stable.
- Compare width is exactly W bits. There is no sign extension beyond W and no overflow path.
- Termination is checked after each phase, with count = phases executed including the current one:
  - Early exit: the current phase is ODD and neither it nor the preceding EVEN phase swapped.
  - Bound: count == N.
  - On either condition: dout ← post-phase array, phases ← count, done=1, busy=0, return to IDLE.
- N=2: the ODD phase has no pairs and never swaps. The engine therefore ends after 2 phases.
- start while busy=1 is ignored. descending and din changes while busy have no effect.
- start in the cycle where done=1 is accepted, so back-to-back sorts are allowed.
- dout and phases hold their values until the next completion.

## Timing
- Reset (asynchronous, immediate): busy=0, done=0, dout=0, phases=0, state IDLE, work array cleared.
- Reset mid-sort aborts the sort. No done pulse is issued and dout=0.
- start sampled high at edge E0 while idle: busy=1 after E0.
- Phase k executes at edge E0+k.
- The terminating phase P sets done=1, busy=0 and the new dout/phases after edge E0+P.
- done stays high for exactly one cycle.
- Latency: minimum P=2 for already-sorted input, maximum P=N.
- The next start is accepted at edge E0+P+1 or later.
- Combinational depth per phase: N/2 parallel W-bit comparators feeding 2:1 muxes. No multi-cycle paths.

## Test plan
- N=32, W=32, din = 0..31 ascending, start pulse → phases=2; done is high in cycle E0+2 only; dout equals din; busy is high for exactly 2 cycles.
- N=8, din = {7,6,5,4,3,2,1,0} (word0=7), ascending → dout word i = i; phases=8.
- N=8, din = 0..7, descending=1 → dout word0=7 … word7=0; phases=8.
- SIGNED=1, N=4, W=8, din = {0x7F, 0x80, 0x00, 0xFF}, ascending → dout = {0x80, 0xFF, 0x00, 0x7F}. The same input with SIGNED=0 → dout = {0x00, 0x7F, 0x80, 0xFF}.
- Reverse-sorted input with a second start asserted at E0+3 → second start is ignored; one done pulse at E0+N; the following start after done runs a new sort.
- Reset asserted asynchronously at E0+3 of a reverse-sorted sort → busy=0, done=0, dout=0, phases=0 immediately. A start after reset deassertion gives a correct result.
